// File: rtl/nios_system_4a_button_pkg.sv
// Shared constants for the button debounce block.
package nios_system_4a_button_pkg;

    localparam int unsigned BTN_WIDTH_DEFAULT    = 3;
    localparam int unsigned BTN_DEBOUNCE_DEFAULT = 500000;
    localparam int unsigned BTN_CNT_MAX_W        = 24;

    // Counter width for a given window; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        if (cycles <= 1) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/nios_system_4a_debounce_cell.sv
// One debounce channel: stability counter, accepted level and press/release strobes.
module nios_system_4a_debounce_cell
    import nios_system_4a_button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic s,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             level_d_q;
    logic             press_q;
    logic             release_q;

    // Count consecutive mismatching cycles; accept the new level once the window is full.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            level_d_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_d_q <= level_q;
            press_q   <= level_q & ~level_d_q;
            release_q <= ~level_q & level_d_q;
            if (s == level_q) begin
                // Any return to the accepted level restarts the window.
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= s;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/nios_system_4a_button_debounce.sv
// Synchronises raw push buttons, normalises polarity and debounces each channel.
module nios_system_4a_button_debounce
    import nios_system_4a_button_pkg::*;
#(
    parameter int unsigned WIDTH           = BTN_WIDTH_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    // Released pin level; also the polarity mask that makes 1 mean pressed.
    localparam logic [WIDTH-1:0] RELEASED = (ACTIVE_LOW != 0) ? '1 : '0;

    if (DEBOUNCE_CYCLES < 2 || CNT_W > BTN_CNT_MAX_W) begin : g_bad_window
        $error("DEBOUNCE_CYCLES out of range 2..2^24");
    end

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] s;

    // Two-flop synchroniser; reset to the released level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= RELEASED;
            sync2_q <= RELEASED;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q ^ RELEASED;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        nios_system_4a_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk        (clk),
            .reset_n    (reset_n),
            .s          (s[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end

endmodule
